// File: rtl/display_capture_sequencer.sv
// Display/capture sequencer: selects the value shown on the BCD display (uptime,
// manual channel, auto-rotating channel) and schedules sensor captures with timeout.
module display_capture_sequencer #(
    parameter int NUM_CH    = 2,
    parameter int DATA_W    = 8,
    parameter int TIMEOUT_S = 3,
    parameter int ROT_S     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick_1hz,
    input  logic                     mode_next,
    input  logic                     manual_start,
    input  logic [7:0]               interval,
    output logic                     sensor_start,
    input  logic                     sensor_done,
    input  logic [3:0]               sensor_status,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [3:0]               mode,
    output logic [9:0]               disp_value,
    output logic                     busy,
    output logic [3:0]               last_status,
    output logic [7:0]               capture_cnt,
    output logic [7:0]               error_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT
    } cap_state_t;

    localparam logic [3:0] MODE_AUTO = 4'(NUM_CH + 1);

    cap_state_t        state_q, state_d;
    logic [9:0]        uptime;
    logic [DATA_W-1:0] hold [NUM_CH];
    logic [7:0]        auto_cnt;
    logic [3:0]        rot_cnt;
    logic [2:0]        rot_idx;
    logic [3:0]        to_cnt;
    logic              pending;

    logic              in_auto;
    logic              count_auto;
    logic              auto_fire;
    logic              cap_req;
    logic [7:0]        interval_eff;
    logic              start_capture;
    logic              done_ok;
    logic              done_err;
    logic              timed_out;
    logic [2:0]        sel_idx;
    logic [9:0]        disp_d;

    assign in_auto      = (mode == MODE_AUTO);
    // A mode change in the same clk as a tick wins: the auto/rotation counters clear.
    assign count_auto   = in_auto && tick_1hz && !mode_next;
    assign interval_eff = (interval == 8'd0) ? 8'd1 : interval;
    assign auto_fire    = count_auto && (({1'b0, auto_cnt} + 9'd1) >= {1'b0, interval_eff});
    assign cap_req      = manual_start || auto_fire || pending;

    assign busy         = (state_q != ST_IDLE);
    assign sensor_start = (state_q == ST_START);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        start_capture = 1'b0;
        done_ok       = 1'b0;
        done_err      = 1'b0;
        timed_out     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cap_req) begin
                    state_d       = ST_START;
                    start_capture = 1'b1;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                // A done in the same clk as the final tick counts as done, not timeout.
                if (sensor_done) begin
                    state_d  = ST_IDLE;
                    done_ok  = (sensor_status == 4'd0);
                    done_err = (sensor_status != 4'd0);
                end else if (tick_1hz && (to_cnt == 4'(TIMEOUT_S - 1))) begin
                    state_d   = ST_IDLE;
                    timed_out = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode     <= 4'd0;
            uptime   <= 10'd0;
            auto_cnt <= 8'd0;
            rot_cnt  <= 4'd0;
            rot_idx  <= 3'd0;
        end else begin
            if (tick_1hz) uptime <= uptime + 10'd1;
            if (mode_next) begin
                mode     <= (mode >= MODE_AUTO) ? 4'd0 : mode + 4'd1;
                auto_cnt <= 8'd0;
                rot_cnt  <= 4'd0;
                rot_idx  <= 3'd0;
            end else if (count_auto) begin
                auto_cnt <= auto_fire ? 8'd0 : auto_cnt + 8'd1;
                if (rot_cnt == 4'(ROT_S - 1)) begin
                    rot_cnt <= 4'd0;
                    rot_idx <= (rot_idx == 3'(NUM_CH - 1)) ? 3'd0 : rot_idx + 3'd1;
                end else begin
                    rot_cnt <= rot_cnt + 4'd1;
                end
            end
        end
    end

    // NOTE: the hold array is a handful of flops, so it is reset like any other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= 1'b0;
            to_cnt      <= 4'd0;
            last_status <= 4'd0;
            capture_cnt <= 8'd0;
            error_cnt   <= 8'd0;
            for (int k = 0; k < NUM_CH; k++) hold[k] <= '0;
        end else begin
            if (start_capture)          pending <= 1'b0;
            else if (auto_fire && busy) pending <= 1'b1;

            if (state_q != ST_WAIT) to_cnt <= 4'd0;
            else if (tick_1hz)      to_cnt <= to_cnt + 4'd1;

            if (done_ok) begin
                for (int k = 0; k < NUM_CH; k++) hold[k] <= ch_data[k*DATA_W +: DATA_W];
                capture_cnt <= capture_cnt + 8'd1;
                last_status <= 4'd0;
            end
            if (done_err || timed_out) begin
                if (error_cnt != 8'hFF) error_cnt <= error_cnt + 8'd1;
                last_status <= done_err ? sensor_status : 4'hF;
            end
        end
    end

    always_comb begin
        disp_d  = '0;
        sel_idx = rot_idx;
        if (mode == 4'd0) begin
            disp_d = uptime;
        end else begin
            if (!in_auto) sel_idx = 3'(mode - 4'd1);
            for (int k = 0; k < NUM_CH; k++) begin
                if (sel_idx == 3'(k)) disp_d = 10'(hold[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) disp_value <= 10'd0;
        else     disp_value <= disp_d;
    end

endmodule

// File: tb/tb_display_capture_sequencer.sv
// Self-checking bench for display_capture_sequencer: a second-level behavioural model
// checked every cycle, plus hand-computed expectations for the directed scenarios.
module tb_display_capture_sequencer;

    localparam int NUM_CH    = 2;
    localparam int DATA_W    = 8;
    localparam int TIMEOUT_S = 3;
    localparam int ROT_S     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_1hz = 1'b0;
    logic        mode_next = 1'b0;
    logic        manual_start = 1'b0;
    logic [7:0]  interval = 8'd4;
    logic        sensor_start;
    logic        sensor_done = 1'b0;
    logic [3:0]  sensor_status = 4'd0;
    logic [15:0] ch_data = 16'd0;
    logic [3:0]  mode;
    logic [9:0]  disp_value;
    logic        busy;
    logic [3:0]  last_status;
    logic [7:0]  capture_cnt;
    logic [7:0]  error_cnt;

    display_capture_sequencer #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT_S(TIMEOUT_S), .ROT_S(ROT_S)
    ) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .mode_next(mode_next),
        .manual_start(manual_start), .interval(interval), .sensor_start(sensor_start),
        .sensor_done(sensor_done), .sensor_status(sensor_status), .ch_data(ch_data),
        .mode(mode), .disp_value(disp_value), .busy(busy), .last_status(last_status),
        .capture_cnt(capture_cnt), .error_cnt(error_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;
    int start_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model state in plain integers: seconds spent in AUTO drive both the trigger
    // (every interval-th second) and the rotation (second / ROT_S mod NUM_CH).
    int m_mode, m_uptime, m_disp, m_auto_secs, m_phase, m_wait_secs;
    int m_last_status, m_capture_cnt, m_error_cnt;
    int m_hold [NUM_CH];
    bit m_pending;

    task automatic model_step();
        int nd, ival;
        bit auto_mode, fire, was_busy;
        logic [15:0] shifted;
        if (rst) begin
            m_mode = 0; m_uptime = 0; m_disp = 0; m_auto_secs = 0; m_phase = 0;
            m_wait_secs = 0; m_last_status = 0; m_capture_cnt = 0; m_error_cnt = 0;
            m_pending = 1'b0;
            for (int k = 0; k < NUM_CH; k++) m_hold[k] = 0;
            return;
        end
        auto_mode = (m_mode == NUM_CH + 1);
        if (m_mode == 0)    nd = m_uptime;
        else if (auto_mode) nd = m_hold[(m_auto_secs / ROT_S) % NUM_CH];
        else                nd = m_hold[m_mode - 1];
        ival     = (interval == 8'd0) ? 1 : int'(interval);
        fire     = auto_mode && tick_1hz && !mode_next && (((m_auto_secs + 1) % ival) == 0);
        was_busy = (m_phase != 0);
        case (m_phase)
            0: if (manual_start || fire || m_pending) begin
                   m_phase   = 1;
                   m_pending = 1'b0;
               end
            1: begin
                   m_phase     = 2;
                   m_wait_secs = 0;
               end
            default: begin
                if (sensor_done) begin
                    if (sensor_status == 4'd0) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            shifted  = ch_data >> (k * DATA_W);
                            m_hold[k] = int'(shifted[7:0]);
                        end
                        m_capture_cnt = (m_capture_cnt + 1) % 256;
                        m_last_status = 0;
                    end else begin
                        m_error_cnt   = (m_error_cnt < 255) ? m_error_cnt + 1 : 255;
                        m_last_status = int'(sensor_status);
                    end
                    m_phase = 0;
                end else if (tick_1hz) begin
                    m_wait_secs++;
                    if (m_wait_secs == TIMEOUT_S) begin
                        m_error_cnt   = (m_error_cnt < 255) ? m_error_cnt + 1 : 255;
                        m_last_status = 15;
                        m_phase       = 0;
                    end
                end
            end
        endcase
        if (fire && was_busy) m_pending = 1'b1;
        if (tick_1hz) m_uptime = (m_uptime + 1) % 1024;
        if (mode_next) begin
            m_mode      = auto_mode ? 0 : m_mode + 1;
            m_auto_secs = 0;
        end else if (auto_mode && tick_1hz) begin
            m_auto_secs++;
        end
        m_disp = nd;
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            check("mode", 32'(mode), 32'(m_mode));
            check("disp_value", 32'(disp_value), 32'(m_disp));
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("sensor_start", 32'(sensor_start), 32'(m_phase == 1));
            check("last_status", 32'(last_status), 32'(m_last_status));
            check("capture_cnt", 32'(capture_cnt), 32'(m_capture_cnt));
            check("error_cnt", 32'(error_cnt), 32'(m_error_cnt));
            if (sensor_start === 1'b1) start_pulses++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_mode();
        mode_next = 1'b1; step(); mode_next = 1'b0; step();
    endtask

    task automatic tick_gap();
        tick_1hz = 1'b1; step(); tick_1hz = 1'b0; step();
    endtask

    logic [9:0] exp_disp [8] = '{10'h37, 10'h2A, 10'h2A, 10'h22, 10'h22, 10'h11, 10'h11, 10'h44};
    int p0;

    initial begin
        step(); step();
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_mode", 32'(mode), 0);
        check("reset_disp", 32'(disp_value), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_capture_cnt", 32'(capture_cnt), 0);

        // Uptime display and wrap.
        repeat (5) begin tick_1hz = 1'b1; step(); end
        tick_1hz = 1'b0; step();
        check("uptime5_disp", 32'(disp_value), 5);
        check("uptime5_mode", 32'(mode), 0);
        repeat (1020) begin tick_1hz = 1'b1; step(); end
        tick_1hz = 1'b0; step();
        check("uptime_wrap_disp", 32'(disp_value), 1);

        // Manual capture, then channel 1 view.
        pulse_mode();
        p0 = start_pulses;
        manual_start = 1'b1; step(); manual_start = 1'b0; step();
        ch_data = 16'h2A37; sensor_status = 4'd0; sensor_done = 1'b1; step(); sensor_done = 1'b0; step();
        check("manual_start_pulses", 32'(start_pulses - p0), 1);
        check("manual_ch0_disp", 32'(disp_value), 32'h37);
        check("manual_capture_cnt", 32'(capture_cnt), 1);
        pulse_mode();
        check("manual_ch1_disp", 32'(disp_value), 32'h2A);

        // AUTO with interval 4: captures on seconds 4 and 8, rotation every 2 seconds.
        interval = 8'd4;
        pulse_mode();
        check("auto_mode", 32'(mode), 3);
        for (int t = 1; t <= 8; t++) begin
            tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
            check($sformatf("auto_start_sec%0d", t), 32'(sensor_start), 32'(t % 4 == 0));
            if (t % 4 == 0) begin
                step();
                ch_data = (t == 4) ? 16'h1122 : 16'h3344;
                sensor_done = 1'b1; step(); sensor_done = 1'b0;
            end
            step(); step();
            check($sformatf("auto_disp_sec%0d", t), 32'(disp_value), 32'(exp_disp[t-1]));
        end
        check("auto_capture_cnt", 32'(capture_cnt), 3);

        // Timeout in MANUAL ch0, then a late done.
        pulse_mode(); pulse_mode();
        manual_start = 1'b1; step(); manual_start = 1'b0; step();
        repeat (3) tick_gap();
        check("timeout_busy", 32'(busy), 0);
        check("timeout_status", 32'(last_status), 32'hF);
        check("timeout_error_cnt", 32'(error_cnt), 1);
        check("timeout_hold", 32'(disp_value), 32'h44);
        ch_data = 16'hFFFF; sensor_done = 1'b1; step(); sensor_done = 1'b0; step(); step();
        check("late_done_capture_cnt", 32'(capture_cnt), 3);
        check("late_done_hold", 32'(disp_value), 32'h44);

        // AUTO interval 1 with a slow sensor: one pending capture, then a failure.
        interval = 8'd1;
        pulse_mode(); pulse_mode();
        check("auto2_mode", 32'(mode), 3);
        p0 = start_pulses;
        tick_1hz = 1'b1; step(); tick_1hz = 1'b0; step();
        tick_gap(); tick_gap();
        check("slow_busy", 32'(busy), 1);
        ch_data = 16'h5566; sensor_done = 1'b1; step(); sensor_done = 1'b0;
        step(); step();
        check("pending_start_pulses", 32'(start_pulses - p0), 2);
        ch_data = 16'h9999; sensor_status = 4'h2; sensor_done = 1'b1; step();
        sensor_done = 1'b0; sensor_status = 4'd0;
        step(); step(); step();
        check("fail_error_cnt", 32'(error_cnt), 2);
        check("fail_status", 32'(last_status), 2);
        check("fail_capture_cnt", 32'(capture_cnt), 4);
        check("fail_disp_unchanged", 32'(disp_value), 32'h55);
        check("no_extra_pulses", 32'(start_pulses - p0), 2);

        // Reset while waiting.
        manual_start = 1'b1; step(); manual_start = 1'b0; step();
        check("pre_reset_busy", 32'(busy), 1);
        rst = 1'b1; step();
        check("rst_wait_mode", 32'(mode), 0);
        check("rst_wait_disp", 32'(disp_value), 0);
        check("rst_wait_busy", 32'(busy), 0);
        check("rst_wait_start", 32'(sensor_start), 0);
        check("rst_wait_status", 32'(last_status), 0);
        check("rst_wait_error_cnt", 32'(error_cnt), 0);
        rst = 1'b0;
        sensor_done = 1'b1; step(); sensor_done = 1'b0; step();
        check("post_reset_done_ignored", 32'(capture_cnt), 0);

        // Done in the same clk as the timeout tick counts as done.
        manual_start = 1'b1; step(); manual_start = 1'b0; step();
        tick_gap(); tick_gap();
        ch_data = 16'h0708; tick_1hz = 1'b1; sensor_done = 1'b1; step();
        tick_1hz = 1'b0; sensor_done = 1'b0; step();
        check("done_beats_timeout_cap", 32'(capture_cnt), 1);
        check("done_beats_timeout_err", 32'(error_cnt), 0);

        // Manual and auto in the same clk give one capture; mode_next with tick leaves AUTO.
        interval = 8'd1;
        pulse_mode(); pulse_mode(); pulse_mode();
        p0 = start_pulses;
        tick_1hz = 1'b1; manual_start = 1'b1; step(); tick_1hz = 1'b0; manual_start = 1'b0; step();
        ch_data = 16'hABCD; sensor_done = 1'b1; step(); sensor_done = 1'b0; step(); step();
        check("simultaneous_sources_pulses", 32'(start_pulses - p0), 1);
        check("simultaneous_capture_cnt", 32'(capture_cnt), 2);
        tick_1hz = 1'b1; mode_next = 1'b1; step(); tick_1hz = 1'b0; mode_next = 1'b0; step(); step();
        check("mode_wrap", 32'(mode), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/display_capture_sequencer.md
DISPLAY_CAPTURE_SEQUENCER -- requirements
Module: display_capture_sequencer

Interface
REQ-001 Parameter NUM_CH, default 2: number of sensor channels, 1..8.
REQ-002 Parameter DATA_W, default 8: width of each channel value.
REQ-003 Parameter TIMEOUT_S, default 3: capture timeout in seconds, counted in tick_1hz pulses, range 1..15.
REQ-004 Parameter ROT_S, default 2: seconds each channel is shown in AUTO mode before the display rotates, range 1..15.
REQ-005 Port clk, input, 1 bit: the single clock. Every register is in this domain.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port tick_1hz, input, 1 bit: one-clk strobe, once per second.
REQ-008 Port mode_next, input, 1 bit: one-clk strobe from debounced button; advances the mode.
REQ-009 Port manual_start, input, 1 bit: one-clk strobe from debounced button; requests a capture.
REQ-010 Port interval, input, 8 bits: auto-capture period in seconds. A value of 0 is treated as 1.
REQ-011 Port sensor_start, output, 1 bit: one-clk capture request to the sensor driver.
REQ-012 Port sensor_done, input, 1 bit: one-clk strobe; the driver has finished a capture.
REQ-013 Port sensor_status, input, 4 bits: driver result, sampled on sensor_done; 0 means OK.
REQ-014 Port ch_data, input, NUM_CH*DATA_W bits: channel k occupies bits [k*DATA_W +: DATA_W]; sampled on sensor_done.
REQ-015 Port mode, output, 4 bits: current mode.
REQ-016 Port disp_value, output, 10 bits: value sent to the BCD converter, zero-extended.
REQ-017 Port busy, output, 1 bit: a capture is in flight.
REQ-018 Port last_status, output, 4 bits: result of the most recent capture; 4'hF means timeout.
REQ-019 Port capture_cnt, output, 8 bits: number of successful captures, wrapping.
REQ-020 Port error_cnt, output, 8 bits: number of failed or timed-out captures, saturating at 255.

Function
REQ-021 Modes:
- 0 = UPTIME.
- 1..NUM_CH = MANUAL, showing channel mode-1.
- NUM_CH+1 = AUTO.
- mode_next increments the mode; the mode wraps from NUM_CH+1 to 0.
REQ-022 Uptime counter: 10 bits, incremented on every tick_1hz in all modes, wraps 1023->0.
REQ-023 disp_value per mode:
- UPTIME: the uptime counter.
- MANUAL: the held value of the selected channel.
- AUTO: the held value of the channel given by rot_idx.
- disp_value is registered, one clk latency after mode or data changes.
REQ-024 Capture FSM states: IDLE, START, WAIT.
- IDLE->START on a capture request.
- START asserts sensor_start for exactly one clk, then goes to WAIT.
- WAIT->IDLE on sensor_done, or on timeout.
REQ-025 busy is 1 in START and WAIT, and 0 in IDLE.
REQ-026 Capture sources:
- manual_start in any mode.
- Auto trigger in AUTO mode.
- Simultaneous sources produce exactly one capture.
REQ-027 manual_start while busy=1 is dropped.
REQ-028 An auto trigger while busy=1 sets a pending flag. A pending request starts a capture on the first IDLE cycle. Pending is cleared when that capture starts.
REQ-029 Auto interval counter:
- Counts tick_1hz pulses only while in AUTO.
- When the count reaches max(interval,1), it fires an auto trigger and restarts at 0.
- It is cleared to 0 whenever the mode changes, so the first auto capture occurs interval seconds after entering AUTO.
REQ-030 Rotation counter:
- Counts tick_1hz pulses in AUTO.
- Every ROT_S ticks, rot_idx advances, wrapping from NUM_CH-1 to 0.
- Counter and rot_idx are cleared when the mode changes.
REQ-031 Successful capture, sensor_done with sensor_status==0:
- All NUM_CH channels are latched into the hold registers together.
- capture_cnt increments by 1.
- last_status is set to 0.
REQ-032 Failed capture, sensor_done with sensor_status!=0:
- Hold registers are unchanged.
- error_cnt increments by 1.
- last_status is set to sensor_status.
REQ-033 Timeout:
- Counts tick_1hz pulses while in WAIT.
- At TIMEOUT_S ticks: return to IDLE, error_cnt increments by 1, last_status is set to 4'hF.
- Any sensor_done arriving later while in IDLE is ignored.
REQ-034 sensor_done in the same clk as the timeout tick is treated as done; the timeout does not count.
REQ-035 sensor_done while in IDLE or START is ignored.
REQ-036 mode_next and tick_1hz in the same clk: the uptime counter increments, and the auto and rotation counters clear.
REQ-037 A mode change does not abort a capture in flight.

Reset
REQ-038 While rst=1 at a clk edge, all of the following are set to 0 and held there:
- mode, disp_value, uptime, the hold registers, the auto, rotation and timeout counters, rot_idx, pending, busy, sensor_start, last_status, capture_cnt, error_cnt.
- The FSM is set to IDLE.
REQ-039 Reset during WAIT returns the FSM to IDLE with no count change. A sensor_done after reset is ignored.

Verification (NUM_CH=2, DATA_W=8, TIMEOUT_S=3, ROT_S=2)
REQ-040 Reset, then 5 ticks -> disp_value=5, mode=0.
- Then 1020 more ticks -> disp_value=1 (uptime wraps).
REQ-041 mode_next x1, manual_start, then sensor_done with status=0 and ch_data=16'h2A37:
- One sensor_start pulse.
- disp_value=0x37.
- capture_cnt=1.
- mode_next again -> disp_value=0x2A.
REQ-042 Enter AUTO (mode=3) with interval=4:
- sensor_start on the 4th tick, then again on the 8th.
- With sensor_done returned, disp_value alternates ch0/ch1 every 2 ticks.
REQ-043 manual_start, then 3 ticks with no sensor_done:
- busy drops, last_status=4'hF, error_cnt=1, hold values unchanged.
- A late sensor_done is ignored.
REQ-044 In AUTO with interval=1, hold sensor_done off for 2 ticks:
- Exactly one pending capture issues after done.
- sensor_done with status=4'h2 -> error_cnt+1, last_status=2, display unchanged.
REQ-045 Assert rst mid-WAIT -> all outputs 0, FSM IDLE; a subsequent sensor_done does not change capture_cnt.
